acc_deshifter_mc: RTL and testbench

- Multi-channel, width-parametrised successor to the single-lane accumulator deshifter.
- NUM_CH serial lanes share one bit-enable. Each lane deserialises DATA_WIDTH-bit words. The NUM_CH words for one index are packed into one SRAM word and written to consecutive addresses from start_addr.
- New behaviour: optional accumulate mode (read-add-write into SRAM) and selectable bit order.
- Sits between the serial MAC array output and the activation SRAM.

---
 rtl/acc_deshift_pkg.sv | 20 ++
 rtl/acc_deshifter_mc_deser_lane.sv | 32 +++
 rtl/acc_deshifter_mc.sv | 126 ++++++++++++
 tb/tb_acc_deshifter_mc.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_deshift_pkg.sv
// Shared types and helpers for the multi-channel accumulator deshifter.
package acc_deshift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic ACC_OVERWRITE = 1'b0;
  localparam logic ACC_ADD       = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/acc_deshifter_mc_deser_lane.sv
// One serial lane: shift register with enable; word_next exposes the value
// after this edge so the top can capture a word on the edge that completes it.
module deser_lane #(
  parameter int DATA_WIDTH = 32,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  shift_en,
  input  logic                  bit_in,
  output logic [DATA_WIDTH-1:0] word_next
);

  logic [DATA_WIDTH-1:0] word_reg;

  // LSB-first shifts right so the first bit ends in bit 0; MSB-first shifts left.
  always_comb begin
    word_next = word_reg;
    if (shift_en) begin
      if (MSB_FIRST) word_next = {word_reg[DATA_WIDTH-2:0], bit_in};
      else           word_next = {bit_in, word_reg[DATA_WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  word_reg <= '0;
    else if (clr)  word_reg <= '0;
    else           word_reg <= word_next;
  end

endmodule

// File: rtl/acc_deshifter_mc.sv
// Deserialises NUM_CH serial lanes into packed SRAM words, either overwriting
// or read-add-writing each word at consecutive addresses from start_addr.
module acc_deshifter_mc
  import acc_deshift_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int SRAM_DEPTH = 1024,
  parameter bit MSB_FIRST  = 1'b0,
  localparam int ADDR_W    = clog2(SRAM_DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         shift_start,
  input  logic                         acc_mode,
  input  logic [ADDR_W-1:0]            start_addr,
  input  logic [ADDR_W-1:0]            img_size,
  output logic                         shift_idle,
  input  logic [NUM_CH-1:0]            serial_input,
  input  logic                         serial_en,
  output logic                         sram_en,
  output logic                         sram_we,
  output logic [ADDR_W-1:0]            sram_addr,
  output logic [NUM_CH*DATA_WIDTH-1:0] sram_wdata,
  input  logic [NUM_CH*DATA_WIDTH-1:0] sram_rdata
);

  localparam int BIT_W = clog2(DATA_WIDTH);
  localparam int PW    = NUM_CH * DATA_WIDTH;

  state_e            state_reg, state_next;
  logic [BIT_W-1:0]  bit_cnt_reg;
  logic [ADDR_W-1:0] word_idx_reg, base_reg, size_reg, sram_addr_reg;
  logic              mode_reg, sram_en_reg, sram_we_reg;
  logic [PW-1:0]     hold_reg, lane_next_vec, sum_vec;
  logic              start_go, shift_go, word_done, last_word;

  assign start_go  = (state_reg == ST_IDLE) && shift_start;
  assign shift_go  = (state_reg == ST_SHIFT) && serial_en;
  assign word_done = shift_go && (bit_cnt_reg == BIT_W'(DATA_WIDTH - 1));
  assign last_word = word_done && (word_idx_reg == size_reg);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
      deser_lane #(.DATA_WIDTH(DATA_WIDTH), .MSB_FIRST(MSB_FIRST)) u_lane (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (start_go),
        .shift_en (shift_go),
        .bit_in   (serial_input[gi]),
        .word_next(lane_next_vec[gi*DATA_WIDTH +: DATA_WIDTH])
      );
      // Per-lane sum wraps inside its own field; no carry reaches the next lane.
      assign sum_vec[gi*DATA_WIDTH +: DATA_WIDTH] =
        hold_reg[gi*DATA_WIDTH +: DATA_WIDTH] + sram_rdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (shift_start) state_next = ST_SHIFT;
      ST_SHIFT: if (last_word)   state_next = ST_DRAIN;
      ST_DRAIN: if (sram_en_reg && sram_we_reg) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    shift_idle = (state_reg == ST_IDLE);
    sram_wdata = (sram_we_reg && mode_reg == ACC_ADD) ? sum_vec : hold_reg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_reg  <= '0;
      word_idx_reg <= '0;
      base_reg     <= '0;
      size_reg     <= '0;
      mode_reg     <= ACC_OVERWRITE;
    end else if (start_go) begin
      bit_cnt_reg  <= '0;
      word_idx_reg <= '0;
      base_reg     <= start_addr;
      size_reg     <= img_size;
      mode_reg     <= acc_mode;
    end else if (shift_go) begin
      bit_cnt_reg <= word_done ? '0 : bit_cnt_reg + 1'b1;
      if (word_done) word_idx_reg <= word_idx_reg + 1'b1;
    end
  end

  // A completed word issues a write (overwrite) or a read that is followed
  // next cycle by the write of the summed data at the same address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sram_en_reg   <= 1'b0;
      sram_we_reg   <= 1'b0;
      sram_addr_reg <= '0;
      hold_reg      <= '0;
    end else begin
      sram_en_reg <= 1'b0;
      sram_we_reg <= 1'b0;
      if (word_done) begin
        sram_en_reg   <= 1'b1;
        sram_we_reg   <= (mode_reg == ACC_OVERWRITE);
        sram_addr_reg <= base_reg + word_idx_reg;
        hold_reg      <= lane_next_vec;
      end else if (sram_en_reg && !sram_we_reg) begin
        sram_en_reg <= 1'b1;
        sram_we_reg <= 1'b1;
      end
    end
  end

  assign sram_en   = sram_en_reg;
  assign sram_we   = sram_we_reg;
  assign sram_addr = sram_addr_reg;

endmodule

// File: tb/tb_acc_deshifter_mc.sv
// Directed bench: main 4x32 LSB-first instance with an SRAM model, plus a
// 1x8 MSB-first instance for bit-order checks.
module tb_acc_deshifter_mc;

  localparam int NC = 4;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int PW = NC * DW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          shift_start = 1'b0, acc_mode = 1'b0, serial_en = 1'b0;
  logic [AW-1:0] start_addr = '0, img_size = '0;
  logic [NC-1:0] serial_input = '0;
  logic          shift_idle, sram_en, sram_we;
  logic [AW-1:0] sram_addr;
  logic [PW-1:0] sram_wdata, sram_rdata;

  logic       s8_start = 1'b0, s8_ser_en = 1'b0;
  logic [0:0] s8_in = '0;
  logic       s8_idle, s8_sram_en, s8_sram_we;
  logic [3:0] s8_addr;
  logic [7:0] s8_wdata;
  logic [7:0] s8_rdata = '0;

  logic [PW-1:0] mem [0:1023];
  logic [PW-1:0] log_data[$];
  logic [AW-1:0] log_addr[$];
  logic          log_we[$];
  int            log_cyc[$];
  logic [7:0]    log8[$];

  int n_cmp = 0, n_err = 0;
  int cyc = 0, last_cyc = 0, idle_cyc = 0;

  acc_deshifter_mc #(.NUM_CH(NC), .DATA_WIDTH(DW), .SRAM_DEPTH(1024), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .shift_start(shift_start), .acc_mode(acc_mode),
    .start_addr(start_addr), .img_size(img_size), .shift_idle(shift_idle),
    .serial_input(serial_input), .serial_en(serial_en), .sram_en(sram_en),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  acc_deshifter_mc #(.NUM_CH(1), .DATA_WIDTH(8), .SRAM_DEPTH(16), .MSB_FIRST(1'b1)) dut8 (
    .clk(clk), .reset_n(reset_n), .shift_start(s8_start), .acc_mode(1'b0),
    .start_addr(4'd0), .img_size(4'd1), .shift_idle(s8_idle),
    .serial_input(s8_in), .serial_en(s8_ser_en), .sram_en(s8_sram_en),
    .sram_we(s8_sram_we), .sram_addr(s8_addr), .sram_wdata(s8_wdata), .sram_rdata(s8_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= mem[sram_addr];
    end
  end

  always @(negedge clk) begin
    if (sram_en === 1'b1) begin
      log_data.push_back(sram_wdata);
      log_addr.push_back(sram_addr);
      log_we.push_back(sram_we);
      log_cyc.push_back(cyc);
      $display("[%0d] strobe we=%0b addr=%0d wdata=%h", cyc, sram_we, sram_addr, sram_wdata);
    end
    if (s8_sram_en === 1'b1 && s8_sram_we === 1'b1) begin
      log8.push_back(s8_wdata);
      $display("[%0d] lane8 write addr=%0d wdata=%h", cyc, s8_addr, s8_wdata);
    end
  end

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input int i);
    logic [PW-1:0] w;
    for (int c = 0; c < NC; c++) w[c*DW +: DW] = 32'(i * 16 + c);
    return w;
  endfunction

  function automatic logic [PW-1:0] splat(input logic [DW-1:0] v);
    return {NC{v}};
  endfunction

  task automatic clear_log();
    log_data.delete(); log_addr.delete(); log_we.delete(); log_cyc.delete();
  endtask

  task automatic start_run(input logic [AW-1:0] a, input logic [AW-1:0] n, input logic m);
    start_addr = a; img_size = n; acc_mode = m; shift_start = 1'b1;
    @(negedge clk);
    shift_start = 1'b0;
  endtask

  task automatic send_word(input logic [PW-1:0] w, input bit gaps, input int nbits);
    int g;
    for (int b = 0; b < nbits; b++) begin
      if (gaps) begin
        g = $urandom_range(0, 5);
        repeat (g) begin serial_en = 1'b0; @(negedge clk); end
      end
      for (int c = 0; c < NC; c++) serial_input[c] = w[c*DW + b];
      serial_en = 1'b1;
      last_cyc = cyc;
      @(negedge clk);
    end
    serial_en = 1'b0;
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (shift_idle) begin seen = 1'b1; idle_cyc = cyc; end
    end
    if (!seen) check("idle_timeout", 0, 1);
  endtask

  initial begin
    logic [15:0] seq8;
    logic [PW-1:0] pre, exp;

    repeat (3) @(negedge clk);
    check("rst_idle", shift_idle, 1);
    check("rst_en", sram_en, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_wdata", sram_wdata, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Overwrite run, 10 words from address 0
    clear_log();
    start_run(10'd0, 10'd9, 1'b0);
    for (int i = 0; i < 10; i++) send_word(mk(i), 1'b0, DW);
    wait_idle();
    check("ow_count", log_data.size(), 10);
    for (int i = 0; i < 10 && i < log_data.size(); i++) begin
      check($sformatf("ow_addr%0d", i), log_addr[i], i);
      check($sformatf("ow_data%0d", i), {log_we[i], log_data[i]}, {1'b1, mk(i)});
    end
    if (log_cyc.size() == 10) begin
      check("ow_latency", log_cyc[9] - last_cyc, 1);
      check("ow_idle_rise", idle_cyc - log_cyc[9], 1);
    end

    // Accumulate: preload 100 at 5..7, then add 7
    start_run(10'd5, 10'd2, 1'b0);
    for (int i = 0; i < 3; i++) send_word(splat(32'd100), 1'b0, DW);
    wait_idle();
    clear_log();
    start_run(10'd5, 10'd2, 1'b1);
    for (int i = 0; i < 3; i++) send_word(splat(32'd7), 1'b0, DW);
    wait_idle();
    check("acc_count", log_data.size(), 6);
    for (int i = 0; i < 3 && log_data.size() == 6; i++) begin
      check($sformatf("acc_rd%0d", i), {log_we[2*i], log_addr[2*i]}, {1'b0, 10'(5 + i)});
      check($sformatf("acc_wr%0d", i), {log_we[2*i+1], log_addr[2*i+1]}, {1'b1, 10'(5 + i)});
      check($sformatf("acc_gap%0d", i), log_cyc[2*i+1] - log_cyc[2*i], 1);
      check($sformatf("acc_sum%0d", i), log_data[2*i+1], splat(32'd107));
    end
    if (log_cyc.size() == 6) check("acc_latency", log_cyc[5] - last_cyc, 2);
    check("acc_mem6", mem[6], splat(32'd107));

    // Per-lane wrap without crosstalk
    pre = {32'd5, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF};
    start_run(10'd0, 10'd0, 1'b0);
    send_word(pre, 1'b0, DW);
    wait_idle();
    clear_log();
    start_run(10'd0, 10'd0, 1'b1);
    send_word(splat(32'd2), 1'b0, DW);
    wait_idle();
    exp = {32'd7, 32'd1, 32'd2, 32'd1};
    check("wrap_count", log_data.size(), 2);
    check("wrap_mem0", mem[0], exp);

    // Random serial_en gaps give the same contents
    clear_log();
    start_run(10'd20, 10'd9, 1'b0);
    for (int i = 0; i < 10; i++) send_word(mk(i), 1'b1, DW);
    wait_idle();
    check("gap_count", log_data.size(), 10);
    for (int i = 0; i < 10; i += 3) check($sformatf("gap_mem%0d", 20 + i), mem[20 + i], mk(i));

    // serial_en in IDLE is ignored
    clear_log();
    for (int i = 0; i < 40; i++) begin
      serial_input = 4'($urandom_range(0, 15)); serial_en = 1'b1; @(negedge clk);
    end
    serial_en = 1'b0;
    @(negedge clk);
    check("idle_noise", log_data.size(), 0);
    check("idle_stay", shift_idle, 1);

    // Address wrap 1023 -> 0
    clear_log();
    start_run(10'd1023, 10'd1, 1'b0);
    send_word(mk(3), 1'b0, DW);
    send_word(mk(4), 1'b0, DW);
    wait_idle();
    check("wrap_n", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      check("wrap_a0", log_addr[0], 10'd1023);
      check("wrap_a1", log_addr[1], 10'd0);
    end

    // MSB-first 8-bit lane: words 0x81 then 0xC0
    seq8 = 16'b1000_0001_1100_0000;
    s8_start = 1'b1; @(negedge clk); s8_start = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      s8_in[0] = seq8[i]; s8_ser_en = 1'b1; @(negedge clk);
    end
    s8_ser_en = 1'b0;
    repeat (3) @(negedge clk);
    check("msb_count", log8.size(), 2);
    if (log8.size() == 2) begin
      check("msb_w0", log8[0], 8'h81);
      check("msb_w1", log8[1], 8'hC0);
    end
    check("msb_idle", s8_idle, 1);

    // shift_start re-pulsed mid-run is ignored
    clear_log();
    start_run(10'd40, 10'd1, 1'b0);
    send_word(mk(1), 1'b0, DW);
    start_run(10'd100, 10'd5, 1'b1);
    send_word(mk(2), 1'b0, DW);
    wait_idle();
    check("rep_count", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      check("rep_a1", {log_we[1], log_addr[1]}, {1'b1, 10'd41});
      check("rep_d1", log_data[1], mk(2));
    end

    // Reset after three words plus a partial word
    clear_log();
    start_run(10'd60, 10'd9, 1'b0);
    for (int i = 0; i < 3; i++) send_word(mk(i), 1'b0, DW);
    send_word(mk(3), 1'b0, 5);
    reset_n = 1'b0;
    #1;
    check("abort_idle", shift_idle, 1);
    check("abort_en", sram_en, 0);
    check("abort_wdata", sram_wdata, 0);
    check("abort_count", log_addr.size(), 3);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("abort_quiet", log_addr.size(), 3);
    clear_log();
    start_run(10'd200, 10'd0, 1'b0);
    send_word(mk(7), 1'b0, DW);
    wait_idle();
    check("restart_n", log_addr.size(), 1);
    if (log_addr.size() == 1) begin
      check("restart_addr", log_addr[0], 10'd200);
      check("restart_data", log_data[0], mk(7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
